// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Types and defaults for the fetch-to-memory interface unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    import len5_pkg::*;

    // Default number of in-flight plus buffered fetches.
    localparam int unsigned c_FETCH_DEPTH = 4;

    // One fetched instruction as handed to the decode stage.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            except;
    } fetch_out_t;

endpackage
`default_nettype wire

// File: rtl/len5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : len5_pkg
//  Description : Core-wide architectural widths shared by the fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package len5_pkg;

    // Fetch address width.
    localparam int unsigned XLEN = 64;

    // Instruction word width.
    localparam int unsigned ILEN = 32;

endpackage
`default_nettype wire

// File: rtl/fetch_mem_if_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_mem_if_if
//  Description : Instruction-memory read bus: request channel plus in-order,
//                non-back-pressured response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_mem_if_if;

    import len5_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_instr;
    logic            rsp_except;

    // Fetch unit side: issues requests, consumes responses.
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr,
        input  rsp_except
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_instr,
        output rsp_except
    );

endinterface
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Generic single-clock FIFO with occupancy count and a
//                synchronous clear. Head is shown combinationally on data_o.
//                DEPTH must be a power of two so the pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    // Storage carries no reset: an entry is only ever read after being written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; a clear overrides any same-cycle push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_mem_if
//  Description : Bridges the PC generator to instruction memory. Tracks the
//                PCs of outstanding reads, pairs them with in-order responses,
//                buffers results for decode, and discards stale responses
//                after a flush. A shared credit bounds outstanding + buffered
//                + still-to-be-discarded fetches to DEPTH, so the output FIFO
//                can never overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_mem_if
    import len5_pkg::*;
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = c_FETCH_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  pc_valid_i,
    input  logic [XLEN-1:0]       pc_i,
    output logic                  pc_ready_o,
    fetch_mem_if_if.master        mem,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output fetch_out_t            instr_o
);

    localparam int unsigned          c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned          c_SUM_W   = c_CNT_W + 2;
    localparam int unsigned          c_OUT_W   = $bits(fetch_out_t);
    localparam logic [c_SUM_W-1:0]   c_DEPTH_S = c_SUM_W'(DEPTH);

    // The PC FIFO occupancy is the pending count: one entry per outstanding read.
    logic [c_CNT_W-1:0] w_pending_cnt;
    logic [c_CNT_W-1:0] w_buf_cnt;
    logic [c_CNT_W-1:0] r_discard_cnt;

    logic [c_SUM_W-1:0] w_committed;
    logic               w_credit_ok;
    logic               w_req_valid;
    logic               w_accept;

    logic               w_discard_active;
    logic               w_rsp_owed;
    logic               w_rsp_stale;
    logic               w_rsp_match;
    logic               w_rsp_keep;
    logic               w_instr_pop;

    logic [XLEN-1:0]    w_rsp_pc;
    fetch_out_t         w_push_entry;
    logic [c_OUT_W-1:0] w_head_bits;

    // ---------------------------------------------------------------- request
    assign w_committed = c_SUM_W'(w_pending_cnt) + c_SUM_W'(w_buf_cnt)
                       + c_SUM_W'(r_discard_cnt);
    assign w_credit_ok = (w_committed < c_DEPTH_S);

    // rst_ni gating keeps the request quiet while reset is held.
    assign w_req_valid   = rst_ni & pc_valid_i & ~flush_i & w_credit_ok;
    assign w_accept      = w_req_valid & mem.req_ready;
    assign mem.req_valid = w_req_valid;
    assign mem.req_addr  = pc_i;
    assign pc_ready_o    = w_accept;

    // --------------------------------------------------------------- response
    // Responses arrive in order, so stale ones (pre-flush) always come first.
    assign w_discard_active = (r_discard_cnt != '0);
    assign w_rsp_owed       = mem.rsp_valid & (w_discard_active | (w_pending_cnt != '0));
    assign w_rsp_stale      = mem.rsp_valid & w_discard_active;
    assign w_rsp_match      = mem.rsp_valid & ~w_discard_active & (w_pending_cnt != '0);
    assign w_rsp_keep       = w_rsp_match & ~flush_i;

    assign w_push_entry = '{pc: w_rsp_pc, instr: mem.rsp_instr, except: mem.rsp_except};

    // ----------------------------------------------------------------- output
    assign instr_valid_o = (w_buf_cnt != '0);
    assign w_instr_pop   = instr_valid_o & instr_ready_i;
    assign instr_o       = fetch_out_t'(w_head_bits);

    // Outstanding-read PCs, consumed by every response that belongs to them.
    fifo_sync #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (w_accept),
        .data_i  (pc_i),
        .pop_i   (w_rsp_match),
        .data_o  (w_rsp_pc),
        .count_o (w_pending_cnt)
    );

    // Completed fetches waiting for decode; written only, so no bypass path.
    fifo_sync #(
        .WIDTH (c_OUT_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (w_rsp_keep),
        .data_i  (w_push_entry),
        .pop_i   (w_instr_pop),
        .data_o  (w_head_bits),
        .count_o (w_buf_cnt)
    );

    // On flush every read still owed by memory (minus one answered now) becomes stale.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_discard_cnt <= '0;
        end else if (flush_i) begin
            r_discard_cnt <= r_discard_cnt + w_pending_cnt - c_CNT_W'(w_rsp_owed);
        end else if (w_rsp_stale) begin
            r_discard_cnt <= r_discard_cnt - c_CNT_W'(1);
        end
    end

    // Memory must never answer a read that nobody is waiting for.
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem.rsp_valid && (r_discard_cnt == '0) && (w_pending_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_mem_if
//  Description : Self-checking bench for fetch_mem_if: directed scenarios plus
//                a randomized run against a queue-based memory/decode model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_mem_if;

    import len5_pkg::*;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            pc_valid_i;
    logic [XLEN-1:0] pc_i;
    logic            pc_ready_o;
    logic            instr_valid_o;
    logic            instr_ready_i;
    fetch_out_t      instr_o;

    int n_cmp = 0;
    int n_err = 0;

    fetch_mem_if_if mem_bus ();

    always #5 clk = ~clk;

    fetch_mem_if #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .pc_valid_i    (pc_valid_i),
        .pc_i          (pc_i),
        .pc_ready_o    (pc_ready_o),
        .mem           (mem_bus),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o)
    );

    function automatic fetch_out_t mk_out(logic [XLEN-1:0] pc, logic [ILEN-1:0] ins, logic exc);
        fetch_out_t o;
        o.pc     = pc;
        o.instr  = ins;
        o.except = exc;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i              = 1'b0;
        pc_valid_i           = 1'b0;
        pc_i                 = '0;
        mem_bus.rsp_valid    = 1'b0;
        mem_bus.rsp_instr    = '0;
        mem_bus.rsp_except   = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni            = 1'b0;
        idle_inputs();
        instr_ready_i     = 1'b0;
        mem_bus.req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    // Outputs quiet while reset is held, even with a PC on offer.
    task automatic test_reset();
        rst_ni            = 1'b0;
        idle_inputs();
        pc_valid_i        = 1'b1;
        pc_i              = 64'h1000;
        mem_bus.req_ready = 1'b1;
        instr_ready_i     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_bus.req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b expected 0", mem_bus.req_valid); end
        n_cmp++; if (pc_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_pc_ready: got %b expected 0", pc_ready_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid_o); end
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (mem_bus.req_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_req_valid: got %b expected 1", mem_bus.req_valid); end
        n_cmp++; if (mem_bus.req_addr !== 64'h1000) begin n_err++; $display("FAIL post_reset_req_addr: got %h expected %h", mem_bus.req_addr, 64'h1000); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL post_reset_instr_valid: got %b expected 0", instr_valid_o); end
        pc_valid_i = 1'b0;
        tick();
    endtask

    // PCs 0/4/8, responses two cycles after each request, outputs one cycle after.
    task automatic test_basic_order();
        logic [XLEN-1:0] pcs [3];
        logic [ILEN-1:0] ins [3];
        fetch_out_t      exp_o;
        pcs[0] = 64'h0; pcs[1] = 64'h4; pcs[2] = 64'h8;
        for (int i = 0; i < 3; i++) ins[i] = $urandom;
        do_reset();
        mem_bus.req_ready = 1'b1;
        instr_ready_i     = 1'b1;
        for (int c = 0; c < 7; c++) begin
            pc_valid_i        = (c < 3);
            pc_i              = (c < 3) ? pcs[c % 3] : '0;
            mem_bus.rsp_valid = (c >= 2 && c < 5);
            mem_bus.rsp_instr = ins[(c + 1) % 3];
            #1;
            if (c < 3) begin
                n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_pc_ready c%0d: got %b expected 1", c, pc_ready_o); end
                n_cmp++; if (mem_bus.req_addr !== pcs[c % 3]) begin n_err++; $display("FAIL basic_req_addr c%0d: got %h expected %h", c, mem_bus.req_addr, pcs[c % 3]); end
            end
            if (c >= 3 && c < 6) begin
                exp_o = mk_out(pcs[c - 3], ins[c - 3], 1'b0);
                n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid c%0d: got %b expected 1", c, instr_valid_o); end
                n_cmp++; if (instr_o !== exp_o) begin n_err++; $display("FAIL basic_out c%0d: got %h expected %h", c, instr_o, exp_o); end
            end else begin
                n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_idle c%0d: got %b expected 0", c, instr_valid_o); end
            end
            tick();
        end
        idle_inputs();
    endtask

    // Downstream stalled: four fetches fill the credit, the fifth waits for a pop.
    task automatic test_credit_stall();
        logic [ILEN-1:0] ins [4];
        for (int i = 0; i < 4; i++) ins[i] = $urandom;
        do_reset();
        mem_bus.req_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            pc_valid_i        = 1'b1;
            pc_i              = (c < 4) ? 64'h200 + 64'(4 * c) : 64'h300;
            mem_bus.rsp_valid = (c >= 1 && c < 5);
            mem_bus.rsp_instr = ins[(c + 3) % 4];
            instr_ready_i     = (c == 7);
            #1;
            if (c < 4) begin
                n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_fill_accept c%0d: got %b expected 1", c, pc_ready_o); end
            end else if (c < 8) begin
                n_cmp++; if (mem_bus.req_valid !== 1'b0) begin n_err++; $display("FAIL stall_blocked c%0d: got %b expected 0", c, mem_bus.req_valid); end
            end else begin
                n_cmp++; if (mem_bus.req_valid !== 1'b1) begin n_err++; $display("FAIL stall_released: got %b expected 1", mem_bus.req_valid); end
            end
            if (c == 7) begin
                n_cmp++; if (instr_o !== mk_out(64'h200, ins[0], 1'b0)) begin n_err++; $display("FAIL stall_head: got %h expected %h", instr_o, mk_out(64'h200, ins[0], 1'b0)); end
            end
            if (c == 8) pc_valid_i = 1'b0;
            tick();
        end
        idle_inputs();
    endtask

    // Flush with three reads outstanding; their responses vanish, 0x100 survives.
    task automatic test_flush_pending();
        logic [ILEN-1:0] i100;
        i100 = $urandom;
        do_reset();
        mem_bus.req_ready = 1'b1;
        instr_ready_i     = 1'b1;
        for (int c = 0; c < 11; c++) begin
            flush_i           = (c == 3);
            pc_valid_i        = (c <= 5);
            pc_i              = (c < 3) ? 64'h10 + 64'(4 * c) : (c == 4) ? 64'h100 : 64'h200;
            mem_bus.rsp_valid = (c >= 5 && c <= 8);
            mem_bus.rsp_instr = (c == 8) ? i100 : $urandom;
            #1;
            if (c == 3) begin
                n_cmp++; if (mem_bus.req_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_req: got %b expected 0", mem_bus.req_valid); end
            end
            if (c == 4) begin
                n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_new_accept: got %b expected 1", pc_ready_o); end
            end
            if (c == 5) begin
                n_cmp++; if (mem_bus.req_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard_credit: got %b expected 0", mem_bus.req_valid); end
            end
            if (c == 9) begin
                n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL flush_new_valid: got %b expected 1", instr_valid_o); end
                n_cmp++; if (instr_o !== mk_out(64'h100, i100, 1'b0)) begin n_err++; $display("FAIL flush_new_out: got %h expected %h", instr_o, mk_out(64'h100, i100, 1'b0)); end
            end else if (c >= 3) begin
                n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_dropped c%0d: got %b expected 0", c, instr_valid_o); end
            end
            tick();
        end
        idle_inputs();
    endtask

    // Flush in the same cycle as a response and a pop; nothing owed afterwards.
    task automatic test_flush_coincident();
        logic [ILEN-1:0] ia, i40, i44;
        ia = $urandom; i40 = $urandom; i44 = $urandom;
        do_reset();
        mem_bus.req_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            flush_i           = (c == 3);
            instr_ready_i     = (c >= 3);
            pc_valid_i        = (c < 2) || (c == 4) || (c == 5) || (c == 8);
            pc_i              = (c == 0) ? 64'h30 : (c == 1) ? 64'h34 : (c == 4) ? 64'h40 : 64'h44;
            mem_bus.rsp_valid = (c == 2) || (c == 3) || (c == 5) || (c == 6);
            mem_bus.rsp_instr = (c == 2) ? ia : (c == 5) ? i40 : (c == 6) ? i44 : $urandom;
            #1;
            if (c == 3) begin
                n_cmp++; if (instr_o !== mk_out(64'h30, ia, 1'b0)) begin n_err++; $display("FAIL coin_head: got %h expected %h", instr_o, mk_out(64'h30, ia, 1'b0)); end
            end
            if (c == 4 || c == 5) begin
                n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL coin_accept c%0d: got %b expected 1", c, pc_ready_o); end
            end
            if (c == 4 || c == 5 || c == 8) begin
                n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL coin_idle c%0d: got %b expected 0", c, instr_valid_o); end
            end
            if (c == 6) begin
                n_cmp++; if (instr_o !== mk_out(64'h40, i40, 1'b0) || instr_valid_o !== 1'b1) begin n_err++; $display("FAIL coin_out40: got %b/%h expected 1/%h", instr_valid_o, instr_o, mk_out(64'h40, i40, 1'b0)); end
            end
            if (c == 7) begin
                n_cmp++; if (instr_o !== mk_out(64'h44, i44, 1'b0) || instr_valid_o !== 1'b1) begin n_err++; $display("FAIL coin_out44: got %b/%h expected 1/%h", instr_valid_o, instr_o, mk_out(64'h44, i44, 1'b0)); end
            end
            if (c == 8) begin
                n_cmp++; if (mem_bus.req_valid !== 1'b1) begin n_err++; $display("FAIL coin_credit: got %b expected 1", mem_bus.req_valid); end
                pc_valid_i = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    // Access fault on the second of two fetches.
    task automatic test_except();
        logic [ILEN-1:0] ins [2];
        ins[0] = $urandom; ins[1] = $urandom;
        do_reset();
        mem_bus.req_ready = 1'b1;
        instr_ready_i     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pc_valid_i         = (c < 2);
            pc_i               = (c == 0) ? 64'h20 : 64'h24;
            mem_bus.rsp_valid  = (c == 1) || (c == 2);
            mem_bus.rsp_instr  = ins[(c + 1) % 2];
            mem_bus.rsp_except = (c == 2);
            #1;
            if (c == 2) begin
                n_cmp++; if (instr_o !== mk_out(64'h20, ins[0], 1'b0)) begin n_err++; $display("FAIL except_first: got %h expected %h", instr_o, mk_out(64'h20, ins[0], 1'b0)); end
            end
            if (c == 3) begin
                n_cmp++; if (instr_o !== mk_out(64'h24, ins[1], 1'b1) || instr_valid_o !== 1'b1) begin n_err++; $display("FAIL except_second: got %b/%h expected 1/%h", instr_valid_o, instr_o, mk_out(64'h24, ins[1], 1'b1)); end
            end
            tick();
        end
        idle_inputs();
    endtask

    // Reset with two fetches outstanding and two buffered, then resume.
    task automatic test_reset_midop();
        logic [ILEN-1:0] i50;
        i50 = $urandom;
        do_reset();
        mem_bus.req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pc_valid_i        = 1'b1;
            pc_i              = 64'h60 + 64'(4 * c);
            mem_bus.rsp_valid = (c == 1) || (c == 2);
            mem_bus.rsp_instr = $urandom;
            tick();
        end
        idle_inputs();
        pc_valid_i    = 1'b1;
        instr_ready_i = 1'b1;
        rst_ni        = 1'b0;
        #1;
        n_cmp++; if ({mem_bus.req_valid, pc_ready_o, instr_valid_o} !== 3'b000) begin n_err++; $display("FAIL midrst_async: got %b expected 000", {mem_bus.req_valid, pc_ready_o, instr_valid_o}); end
        tick();
        n_cmp++; if ({mem_bus.req_valid, pc_ready_o, instr_valid_o} !== 3'b000) begin n_err++; $display("FAIL midrst_next: got %b expected 000", {mem_bus.req_valid, pc_ready_o, instr_valid_o}); end
        rst_ni = 1'b1;
        pc_i   = 64'h50;
        #1;
        n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_resume_accept: got %b expected 1", pc_ready_o); end
        tick();
        pc_valid_i        = 1'b0;
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rsp_instr = i50;
        #1;
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_no_bypass: got %b expected 0", instr_valid_o); end
        tick();
        mem_bus.rsp_valid = 1'b0;
        n_cmp++; if (instr_o !== mk_out(64'h50, i50, 1'b0) || instr_valid_o !== 1'b1) begin n_err++; $display("FAIL midrst_out: got %b/%h expected 1/%h", instr_valid_o, instr_o, mk_out(64'h50, i50, 1'b0)); end
        tick();
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_drained: got %b expected 0", instr_valid_o); end
        idle_inputs();
    endtask

    // Random traffic against a model: memory queue of owed reads, queue of expected outputs.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            exc;
        int              due;
    } mem_ent_t;

    task automatic test_random();
        mem_ent_t   mem_q [$];
        fetch_out_t exp_q [$];
        mem_ent_t   ent;
        int         kill_n;
        int         cyc;
        logic       exp_req;
        kill_n = 0;
        cyc    = 0;
        do_reset();
        repeat (3000) begin
            pc_valid_i        = ($urandom_range(0, 3) != 0);
            pc_i              = {$urandom, $urandom};
            pc_i[1:0]         = 2'b00;
            flush_i           = ($urandom_range(0, 39) == 0);
            mem_bus.req_ready = ($urandom_range(0, 3) != 0);
            instr_ready_i     = ($urandom_range(0, 2) != 0);
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                mem_bus.rsp_valid  = 1'b1;
                mem_bus.rsp_instr  = mem_q[0].instr;
                mem_bus.rsp_except = mem_q[0].exc;
            end else begin
                mem_bus.rsp_valid  = 1'b0;
                mem_bus.rsp_instr  = $urandom;
                mem_bus.rsp_except = 1'b0;
            end
            #1;
            exp_req = pc_valid_i && !flush_i && ((mem_q.size() + exp_q.size()) < DEPTH);
            n_cmp++; if (mem_bus.req_valid !== exp_req) begin n_err++; $display("FAIL rnd_req_valid cyc%0d: got %b expected %b", cyc, mem_bus.req_valid, exp_req); end
            n_cmp++; if (pc_ready_o !== (exp_req && mem_bus.req_ready)) begin n_err++; $display("FAIL rnd_pc_ready cyc%0d: got %b expected %b", cyc, pc_ready_o, exp_req && mem_bus.req_ready); end
            n_cmp++; if (mem_bus.req_addr !== pc_i) begin n_err++; $display("FAIL rnd_req_addr cyc%0d: got %h expected %h", cyc, mem_bus.req_addr, pc_i); end
            n_cmp++; if (instr_valid_o !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_instr_valid cyc%0d: got %b expected %b", cyc, instr_valid_o, exp_q.size() != 0); end
            if (exp_q.size() != 0 && instr_ready_i) begin
                n_cmp++; if (instr_o !== exp_q[0]) begin n_err++; $display("FAIL rnd_instr cyc%0d: got %h expected %h", cyc, instr_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (mem_bus.rsp_valid) begin
                ent = mem_q.pop_front();
                if (kill_n > 0) kill_n--;
                else if (!flush_i) exp_q.push_back(mk_out(ent.pc, ent.instr, ent.exc));
            end
            if (flush_i) begin
                exp_q.delete();
                kill_n = mem_q.size();
            end
            if (exp_req && mem_bus.req_ready) begin
                ent.pc    = pc_i;
                ent.instr = $urandom;
                ent.exc   = ($urandom_range(0, 7) == 0);
                ent.due   = cyc + int'($urandom_range(1, 4));
                mem_q.push_back(ent);
            end
            tick();
            cyc++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_credit_stall();
        test_flush_pending();
        test_flush_coincident();
        test_except();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
